// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pwm_ramp slew-rate limiter.
package pwm_pkg;

  // Step interval that replaces a host-written interval of 0.
  localparam logic [31:0] DEFAULT_INTERVAL_C = 32'd1000;

  // Host (E100) write handshake states.
  typedef enum logic [1:0] {
    HS_IDLE,
    HS_LATCH,
    HS_RESP
  } hs_state_t;

  // Ramp engine states, one pwm write per pass through ISSUE/ACK/REL.
  typedef enum logic [2:0] {
    R_RESET,
    R_WAIT,
    R_ISSUE,
    R_ACK,
    R_REL
  } ramp_state_t;

  // a - b on sign-extended operands, so the result can never overflow.
  function automatic logic signed [32:0] diff33(input logic [31:0] a,
                                                input logic [31:0] b);
    return $signed({a[31], a}) - $signed({b[31], b});
  endfunction

endpackage

// File: rtl/pwm_ramp_if.sv
// Host command bus and pwm-block bus of the ramp limiter.
interface pwm_ramp_if;
  logic        ramp_command;
  logic        ramp_response;
  logic [31:0] ramp_target;
  logic [31:0] ramp_step;
  logic [31:0] ramp_interval;
  logic [31:0] ramp_period;
  logic        pwm_command;
  logic        pwm_response;
  logic [31:0] pwm_period;
  logic [31:0] pwm_compare;

  // The ramp limiter itself.
  modport slave (
    input  ramp_command, ramp_target, ramp_step, ramp_interval, ramp_period,
    input  pwm_response,
    output ramp_response, pwm_command, pwm_period, pwm_compare
  );

  // The surroundings: E100 host plus pwm block.
  modport master (
    output ramp_command, ramp_target, ramp_step, ramp_interval, ramp_period,
    output pwm_response,
    input  ramp_response, pwm_command, pwm_period, pwm_compare
  );
endinterface

// File: rtl/ramp_step_calc.sv
// Next compare value: move from current toward target by at most one step.
module ramp_step_calc
  import pwm_pkg::*;
(
  input  logic [31:0] i_current,
  input  logic [31:0] i_target,
  input  logic [31:0] i_step,
  output logic [31:0] o_next
);

  logic signed [32:0] w_diff;
  logic        [32:0] w_mag;

  // Jump when the remaining distance fits in one step, else take a full step.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    o_next = i_target;
    w_diff = diff33(i_target, i_current);
    w_mag  = w_diff[32] ? 33'(-w_diff) : 33'(w_diff);
    if (i_step != 32'd0 && w_mag > {1'b0, i_step}) begin
      o_next = w_diff[32] ? (i_current - i_step) : (i_current + i_step);
    end
  end

endmodule

// File: rtl/pwm_ramp.sv
// Slew-rate limiter in front of the pwm block: takes a target compare from
// the E100 host and walks the pwm compare toward it in bounded steps.
module pwm_ramp
  import pwm_pkg::*;
#(
  parameter logic [31:0] DEFAULT_INTERVAL = DEFAULT_INTERVAL_C
) (
  input  logic        clock,
  input  logic        clock_valid,
  input  logic        reset,
  pwm_ramp_if.slave   bus,
  output logic        ramp_busy,
  output logic [31:0] ramp_current
);

  hs_state_t   r_hs_state;
  ramp_state_t r_ramp_state;
  logic        r_ramp_response;
  logic [31:0] r_target;
  logic [31:0] r_step;
  logic [31:0] r_interval;
  logic [31:0] r_period;
  logic        r_period_dirty;
  logic [31:0] r_tick;
  logic [31:0] r_next;
  logic [31:0] r_current;
  logic        r_pwm_command;
  logic [31:0] r_pwm_compare;
  logic [31:0] r_pwm_period;

  logic [31:0] w_next;
  logic        w_latch;
  logic        w_tick_due;

  ramp_step_calc u_step_calc (
    .i_current (r_current),
    .i_target  (r_target),
    .i_step    (r_step),
    .o_next    (w_next)
  );

  assign w_latch    = (r_hs_state == HS_LATCH);
  assign w_tick_due = (r_tick >= r_interval - 32'd1);

  // Host handshake: latch the new settings once, then acknowledge until the
  // host drops its command.
  always_ff @(posedge clock) begin
    // NOTE: clock_valid low freezes the whole block, reset included.
    if (clock_valid) begin
      if (!reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register sees the values from before this edge.
        r_hs_state      <= HS_IDLE;
        r_ramp_response <= 1'b0;
        r_target        <= '0;
        r_step          <= '0;
        r_interval      <= '0;
        r_period        <= '0;
      end else begin
        case (r_hs_state)
          HS_IDLE: begin
            if (bus.ramp_command) r_hs_state <= HS_LATCH;
          end
          HS_LATCH: begin
            r_target        <= bus.ramp_target;
            r_step          <= bus.ramp_step;
            r_interval      <= (bus.ramp_interval == 32'd0) ? DEFAULT_INTERVAL
                                                            : bus.ramp_interval;
            r_period        <= bus.ramp_period;
            r_ramp_response <= 1'b1;
            r_hs_state      <= HS_RESP;
          end
          HS_RESP: begin
            if (!bus.ramp_command) begin
              r_ramp_response <= 1'b0;
              r_hs_state      <= HS_IDLE;
            end
          end
          default: r_hs_state <= HS_IDLE;
        endcase
      end
    end
  end

  // Ramp engine: on each interval tick, if anything is pending, compute one
  // step and push it to the pwm block through a full command/response cycle.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (!reset) begin
        r_ramp_state   <= R_RESET;
        r_period_dirty <= 1'b0;
        r_tick         <= '0;
        r_next         <= '0;
        r_current      <= '0;
        r_pwm_command  <= 1'b0;
        r_pwm_compare  <= '0;
        r_pwm_period   <= '0;
      end else begin
        // A host latch always wins, so a period arriving during an issue is
        // still written out on a later tick.
        if (w_latch)                    r_period_dirty <= 1'b1;
        else if (r_ramp_state == R_ISSUE) r_period_dirty <= 1'b0;

        case (r_ramp_state)
          R_RESET: begin
            r_tick       <= '0;
            r_ramp_state <= R_WAIT;
          end
          R_WAIT: begin
            if (w_tick_due) begin
              r_tick <= '0;
              if (r_current != r_target || r_period_dirty) begin
                r_next       <= w_next;
                r_ramp_state <= R_ISSUE;
              end
            end else begin
              r_tick <= r_tick + 32'd1;
            end
          end
          R_ISSUE: begin
            r_pwm_compare <= r_next;
            r_pwm_period  <= r_period;
            r_pwm_command <= 1'b1;
            r_ramp_state  <= R_ACK;
          end
          R_ACK: begin
            if (bus.pwm_response) begin
              r_pwm_command <= 1'b0;
              r_current     <= r_next;
              r_ramp_state  <= R_REL;
            end
          end
          R_REL: begin
            if (!bus.pwm_response) r_ramp_state <= R_WAIT;
          end
          default: r_ramp_state <= R_RESET;
        endcase
      end
    end
  end

  // R_RESET only lasts the cycle after reset; it is not counted as busy so
  // every output reads 0 while reset is held.
  assign ramp_busy = (r_current != r_target) || r_period_dirty ||
                     (r_ramp_state != R_WAIT && r_ramp_state != R_RESET);

  assign ramp_current      = r_current;
  assign bus.ramp_response = r_ramp_response;
  assign bus.pwm_command   = r_pwm_command;
  assign bus.pwm_compare   = r_pwm_compare;
  assign bus.pwm_period    = r_pwm_period;

endmodule

// File: doc/pwm_ramp.md
Name: pwm_ramp

Overview:
- Slew-rate limiter that sits directly upstream of the pwm block.
- Accepts a signed target compare value, step size, step interval and PWM period from the E100 through a command/response handshake.
- Moves the PWM's compare toward the target in bounded steps, performing one write per step over the pwm block's pwm_command/pwm_response handshake.
- Prevents the motor drive from jumping abruptly between duty cycles or directions.

Parameters:
- DEFAULT_INTERVAL, 32'd1000: step interval used when ramp_interval is written as 0.

Ports:
- clock  in  1  system clock. One clock domain; reset is synchronous and active-low.
- clock_valid  in  1  when 0, all registers hold.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clock.
- ramp_command  in  1  E100 write request.
- ramp_response  out  1  E100 write acknowledge.
- ramp_target  in  32  signed target compare. Sign selects direction; magnitude sets duty.
- ramp_step  in  32  unsigned maximum compare change per step. 0 means jump to target immediately.
- ramp_interval  in  32  unsigned clock cycles between steps. 0 selects DEFAULT_INTERVAL.
- ramp_period  in  32  PWM period, passed through to the pwm block.
- ramp_busy  out  1  high while current != target or a pwm write is outstanding.
- ramp_current  out  32  last compare value acknowledged by the pwm block.
- pwm_command  out  1  to pwm block.
- pwm_response  in  1  from pwm block.
- pwm_period  out  32  to pwm block.
- pwm_compare  out  32  to pwm block.

Behaviour:
- Reset (reset==0, clock_valid==1):
  - All outputs 0: ramp_response, pwm_command, pwm_compare, pwm_period, ramp_current, ramp_busy.
  - target, step, interval and tick counter cleared; both FSMs go to their first state.
  - Reset mid-handshake abandons the handshake. pwm_command drops on the next cycle.
- E100 host FSM: HS_IDLE -> HS_LATCH -> HS_RESP -> HS_IDLE.
  - HS_IDLE: go to HS_LATCH when ramp_command==1.
  - HS_LATCH (1 cycle): register target, step, interval (0 replaced by DEFAULT_INTERVAL), period; set period_dirty.
  - HS_RESP: ramp_response=1. Stay while ramp_command==1; return to HS_IDLE when it is 0.
  - Response is registered; it rises 2 cycles after command is sampled.
  - A retarget mid-ramp is legal. The ramp continues from ramp_current toward the new target; no restart to 0.
- Ramp FSM: R_RESET -> R_WAIT -> R_ISSUE -> R_ACK -> R_REL -> R_WAIT.
  - R_RESET: clear the tick counter, go to R_WAIT.
  - R_WAIT: the tick counter increments each valid cycle. When tick >= interval-1, clear tick.
    - If current != target or period_dirty, compute next and go to R_ISSUE.
    - Otherwise stay in R_WAIT.
  - Step computation uses 33-bit signed arithmetic: diff = target - current.
    - If step==0 or |diff| <= step: next = target.
    - Else: next = current + step if diff > 0, or current - step if diff < 0.
    - Crossing zero (sign reversal) is a normal step; no special stop.
  - R_ISSUE: drive pwm_compare=next and pwm_period=period, raise pwm_command, clear period_dirty, go to R_ACK.
    - pwm_compare and pwm_period are stable from R_ISSUE until R_REL completes.
  - R_ACK: hold pwm_command=1 until pwm_response==1, then drop pwm_command, set ramp_current=next, go to R_REL.
  - R_REL: wait for pwm_response==0, then go to R_WAIT.
  - No pwm_response timeout. The FSM waits indefinitely.
- Simultaneous events:
  - A host latch in the same cycle as the R_WAIT step decision: the decision uses the old target. The new target is used on the next tick.
  - A host latch while in R_ISSUE/R_ACK/R_REL does not alter the in-flight pwm_compare.
- ramp_busy = (current != target) || period_dirty || ramp FSM not in R_WAIT.
- clock_valid==0 freezes every register, including the tick counter.

Decomposition:
- Shared package pwm_pkg:
  - Host FSM state encodings.
  - Ramp FSM state encodings.
  - DEFAULT_INTERVAL default.
  - 33-bit signed difference helper.
- Sub-module ramp_step_calc: combinational. Inputs current, target, step; outputs next.
- The host FSM, ramp FSM and tick counter remain in pwm_ramp.

Test Plan:
- Reset hold then release; pwm model acks 2 cycles after command -> all outputs 0 during reset; no pwm_command until the first host write.
- Write target=30, step=10, interval=4, period=100 -> pwm_compare sequence 10, 20, 30, one write per ≥4 cycles; busy falls after the ack of 30.
- From current=30, write target=-15, step=20 -> pwm_compare 10, -10, -15 (zero crossing, partial final step).
- step=0, target=70 -> single write of 70 at the next tick.
- Retarget to 0 during R_ACK of a 50 write, starting from current=40 -> the in-flight 50 completes, then 40, 30, ... down to 0.
- Period-only change: target equals current, period 100->200 -> one pwm write with compare unchanged and period 200.
- Assert reset during R_ACK -> pwm_command low next cycle; ramp_current=0.
